// File: rtl/ripple_sched_pkg.sv
// Shared types and constants for the ripple counter scheduler.
package ripple_pkg;

  localparam int unsigned CNT_W_DEF = 3;

  // Client indices, also the encoding of the round-robin pointer.
  localparam logic CLI0 = 1'b0;
  localparam logic CLI1 = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    DONE
  } state_t;

endpackage

// File: rtl/ripple_sched_if.sv
// Client-side request/grant bundle for ripple_sched.
interface ripple_sched_if #(
  parameter int unsigned CNT_W = ripple_pkg::CNT_W_DEF
);

  logic [1:0]       req;
  logic [CNT_W-1:0] len0;
  logic [CNT_W-1:0] len1;
  logic             abort;
  logic [1:0]       gnt;
  logic             busy;
  logic [1:0]       done;
  logic [0:CNT_W-1] q;

  modport master (
    output req, len0, len1, abort,
    input  gnt, busy, done, q
  );

  modport slave (
    input  req, len0, len1, abort,
    output gnt, busy, done, q
  );

endinterface

// File: rtl/ripple_sched_cnt3.sv
// Synchronous up-counter with clear and enable; q[0] is the LSB.
module cnt3 import ripple_pkg::*; #(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clkr,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [0:CNT_W-1] q
);

  logic [CNT_W-1:0] r_cnt;

  // Count register: clear has priority over enable.
  always_ff @(posedge clkr or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Present the count in ascending bit order so q[0] carries the LSB.
  always_comb begin
    q = '0;
    for (int unsigned i = 0; i < CNT_W; i++) begin
      q[i] = r_cnt[i];
    end
  end

endmodule

// File: rtl/ripple_sched.sv
// Round-robin scheduler owning the shared ripple count datapath.
module ripple_sched import ripple_pkg::*; #(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic          clkr,
  input  logic          rst,
  ripple_sched_if.slave bus
);

  state_t           r_state;
  logic [1:0]       r_gnt;
  logic [1:0]       r_done;
  logic             r_busy;
  logic             r_last;
  logic [CNT_W-1:0] r_len;

  logic [0:CNT_W-1] w_q;
  logic [CNT_W-1:0] w_cnt;
  logic [CNT_W-1:0] w_len_m1;
  logic             w_start;
  logic             w_win;
  logic             w_srv;
  logic             w_last_tick;
  logic             w_en;

  assign w_start     = (r_state == IDLE) && (|bus.req);
  // Tie goes to the client not served last; a lone request always wins.
  assign w_win       = (bus.req == 2'b11) ? ~r_last : bus.req[1];
  assign w_srv       = r_gnt[1] ? CLI1 : CLI0;
  assign w_len_m1    = r_len - CNT_W'(1);
  assign w_last_tick = (w_cnt == w_len_m1);
  // Counter clears on entry to LOAD and stops on the final RUN cycle so q
  // holds N-1 afterwards; abort freezes it in place.
  assign w_en        = (r_state == RUN) && !bus.abort && !w_last_tick;

  // Numeric view of the counter for the terminal-count compare.
  always_comb begin
    w_cnt = '0;
    for (int unsigned i = 0; i < CNT_W; i++) begin
      w_cnt[i] = w_q[i];
    end
  end

  cnt3 #(.CNT_W(CNT_W)) u_cnt (
    .clkr (clkr),
    .rst  (rst),
    .clr  (w_start),
    .en   (w_en),
    .q    (w_q)
  );

  // Sequencer FSM with registered grant, busy and done outputs.
  always_ff @(posedge clkr or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_done  <= '0;
      r_busy  <= 1'b0;
      r_last  <= CLI1;
      r_len   <= '0;
    end else begin
      r_done <= '0;
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_state <= LOAD;
            r_busy  <= 1'b1;
            if (w_win == CLI1) begin
              r_gnt <= 2'b10;
              r_len <= bus.len1;
            end else begin
              r_gnt <= 2'b01;
              r_len <= bus.len0;
            end
          end
        end
        LOAD: begin
          if (bus.abort) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_gnt   <= '0;
            r_last  <= w_srv;
          end else begin
            r_state <= RUN;
          end
        end
        RUN: begin
          if (bus.abort) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_gnt   <= '0;
            r_last  <= w_srv;
          end else if (w_last_tick) begin
            r_state <= DONE;
            r_done  <= r_gnt;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_gnt   <= '0;
          r_last  <= w_srv;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_gnt   <= '0;
        end
      endcase
    end
  end

  assign bus.gnt  = r_gnt;
  assign bus.done = r_done;
  assign bus.busy = r_busy;
  assign bus.q    = w_q;

endmodule

// File: tb/tb_ripple_sched.sv
// Directed self-checking bench for ripple_sched.
module tb_ripple_sched;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  logic [2:0] qv;

  ripple_sched_if #(.CNT_W(3)) bus ();

  ripple_sched #(.CNT_W(3)) dut (
    .clkr (clk),
    .rst  (rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Numeric view of q, whose bit 0 is the LSB.
  always_comb begin
    qv = '0;
    for (int i = 0; i < 3; i++) qv[i] = bus.q[i];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (bus.gnt !== 2'b00) begin failures++; $display("FAIL reset_gnt got=%b exp=00", bus.gnt); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.done !== 2'b00) begin failures++; $display("FAIL reset_done got=%b exp=00", bus.done); end
    checks++; if (qv !== 3'd0) begin failures++; $display("FAIL reset_q got=%0d exp=0", qv); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    bus.len0 = 3'd3;
    bus.req  = 2'b01;
    tick(); // LOAD
    checks++; if (bus.gnt !== 2'b01) begin failures++; $display("FAIL single_gnt got=%b exp=01", bus.gnt); end
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL single_busy got=%b exp=1", bus.busy); end
    bus.req = 2'b00;
    tick(); // RUN cycle 1
    checks++; if (qv !== 3'd0) begin failures++; $display("FAIL single_q0 got=%0d exp=0", qv); end
    tick();
    checks++; if (qv !== 3'd1) begin failures++; $display("FAIL single_q1 got=%0d exp=1", qv); end
    tick();
    checks++; if (qv !== 3'd2) begin failures++; $display("FAIL single_q2 got=%0d exp=2", qv); end
    checks++; if (bus.done !== 2'b00) begin failures++; $display("FAIL single_early_done got=%b exp=00", bus.done); end
    tick(); // DONE
    checks++; if (bus.done !== 2'b01) begin failures++; $display("FAIL single_done got=%b exp=01", bus.done); end
    checks++; if (qv !== 3'd2) begin failures++; $display("FAIL single_q_done got=%0d exp=2", qv); end
    tick(); // IDLE
    checks++; if (bus.done !== 2'b00) begin failures++; $display("FAIL single_done_clr got=%b exp=00", bus.done); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL single_busy_clr got=%b exp=0", bus.busy); end
    checks++; if (bus.gnt !== 2'b00) begin failures++; $display("FAIL single_gnt_clr got=%b exp=00", bus.gnt); end
    checks++; if (qv !== 3'd2) begin failures++; $display("FAIL single_q_hold got=%0d exp=2", qv); end
  endtask

  task automatic test_wrap();
    logic [2:0] e;
    bus.len1 = 3'd0;
    bus.req  = 2'b10;
    tick(); // LOAD
    checks++; if (bus.gnt !== 2'b10) begin failures++; $display("FAIL wrap_gnt got=%b exp=10", bus.gnt); end
    bus.req = 2'b00;
    for (int c = 1; c <= 8; c++) begin
      tick();
      e = 3'(c - 1);
      checks++; if (qv !== e) begin failures++; $display("FAIL wrap_q cyc=%0d got=%0d exp=%0d", c, qv, e); end
      checks++; if (bus.done !== 2'b00) begin failures++; $display("FAIL wrap_early_done cyc=%0d got=%b exp=00", c, bus.done); end
    end
    tick(); // DONE
    checks++; if (bus.done !== 2'b10) begin failures++; $display("FAIL wrap_done got=%b exp=10", bus.done); end
    checks++; if (qv !== 3'd7) begin failures++; $display("FAIL wrap_q_end got=%0d exp=7", qv); end
    tick();
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL wrap_busy_clr got=%b exp=0", bus.busy); end
  endtask

  task automatic test_abort();
    bus.len0 = 3'd6;
    bus.req  = 2'b01;
    tick(); // LOAD
    checks++; if (bus.gnt !== 2'b01) begin failures++; $display("FAIL abort_gnt got=%b exp=01", bus.gnt); end
    bus.req = 2'b00;
    tick();
    tick();
    tick(); // RUN cycle 3
    checks++; if (qv !== 3'd2) begin failures++; $display("FAIL abort_q_run3 got=%0d exp=2", qv); end
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.gnt !== 2'b00) begin failures++; $display("FAIL abort_gnt_clr got=%b exp=00", bus.gnt); end
    checks++; if (bus.done !== 2'b00) begin failures++; $display("FAIL abort_done got=%b exp=00", bus.done); end
    checks++; if (qv !== 3'd2) begin failures++; $display("FAIL abort_q_frozen got=%0d exp=2", qv); end
    tick();
    checks++; if (bus.done !== 2'b00) begin failures++; $display("FAIL abort_done_late got=%b exp=00", bus.done); end
    checks++; if (qv !== 3'd2) begin failures++; $display("FAIL abort_q_hold got=%0d exp=2", qv); end
    bus.len0 = 3'd2;
    bus.len1 = 3'd2;
    bus.req  = 2'b11;
    tick();
    checks++; if (bus.gnt !== 2'b10) begin failures++; $display("FAIL abort_tie_gnt got=%b exp=10", bus.gnt); end
    bus.req = 2'b00;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (bus.done !== 2'b00) break;
    end
    checks++; if (bus.done !== 2'b10) begin failures++; $display("FAIL abort_next_done got=%b exp=10", bus.done); end
    tick();
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL abort_next_idle got=%b exp=0", bus.busy); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] got [3];
    int         at  [3];
    logic [1:0] prev;
    int         n;
    got  = '{2'b00, 2'b00, 2'b00};
    at   = '{0, 0, 0};
    prev = 2'b00;
    n    = 0;
    bus.len0 = 3'd1;
    bus.len1 = 3'd2;
    bus.req  = 2'b11;
    for (int cyc = 0; cyc < 60 && n < 3; cyc++) begin
      tick();
      if (bus.gnt !== 2'b00 && prev === 2'b00) begin
        got[n] = bus.gnt;
        at[n]  = cyc;
        n++;
        if (n == 3) bus.req = 2'b00;
      end
      prev = bus.gnt;
    end
    bus.req = 2'b00;
    checks++; if (n !== 3) begin failures++; $display("FAIL rr_count got=%0d exp=3", n); end
    checks++; if (got[0] !== 2'b01) begin failures++; $display("FAIL rr_gnt0 got=%b exp=01", got[0]); end
    checks++; if (got[1] !== 2'b10) begin failures++; $display("FAIL rr_gnt1 got=%b exp=10", got[1]); end
    checks++; if (got[2] !== 2'b01) begin failures++; $display("FAIL rr_gnt2 got=%b exp=01", got[2]); end
    checks++; if (at[1] - at[0] !== 4) begin failures++; $display("FAIL rr_period0 got=%0d exp=4", at[1] - at[0]); end
    checks++; if (at[2] - at[1] !== 5) begin failures++; $display("FAIL rr_period1 got=%0d exp=5", at[2] - at[1]); end
    for (int k = 0; k < 20; k++) begin
      if (bus.busy === 1'b0) break;
      tick();
    end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rr_drain got=%b exp=0", bus.busy); end
  endtask

  task automatic test_len_change();
    int n;
    bus.len0 = 3'd5;
    bus.req  = 2'b01;
    tick(); // LOAD
    checks++; if (bus.gnt !== 2'b01) begin failures++; $display("FAIL lenchg_gnt got=%b exp=01", bus.gnt); end
    tick(); // RUN cycle 1
    bus.len0 = 3'd1;
    bus.req  = 2'b00;
    n = 1;
    for (int k = 0; k < 20; k++) begin
      tick();
      n++;
      if (bus.done !== 2'b00) break;
    end
    checks++; if (n !== 6) begin failures++; $display("FAIL lenchg_cycles got=%0d exp=6", n); end
    checks++; if (bus.done !== 2'b01) begin failures++; $display("FAIL lenchg_done got=%b exp=01", bus.done); end
    checks++; if (qv !== 3'd4) begin failures++; $display("FAIL lenchg_q got=%0d exp=4", qv); end
    tick();
  endtask

  task automatic test_async_rst();
    bus.len0 = 3'd7;
    bus.req  = 2'b01;
    tick(); // LOAD
    bus.req = 2'b00;
    tick();
    tick();
    tick(); // RUN cycle 3
    checks++; if (qv !== 3'd2) begin failures++; $display("FAIL arst_pre_q got=%0d exp=2", qv); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (bus.gnt !== 2'b00) begin failures++; $display("FAIL arst_gnt got=%b exp=00", bus.gnt); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL arst_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.done !== 2'b00) begin failures++; $display("FAIL arst_done got=%b exp=00", bus.done); end
    checks++; if (qv !== 3'd0) begin failures++; $display("FAIL arst_q got=%0d exp=0", qv); end
    tick();
    rst = 1'b0;
    tick();
    checks++; if (bus.done !== 2'b00) begin failures++; $display("FAIL arst_no_done got=%b exp=00", bus.done); end
    bus.len0 = 3'd1;
    bus.len1 = 3'd1;
    bus.req  = 2'b11;
    tick();
    checks++; if (bus.gnt !== 2'b01) begin failures++; $display("FAIL arst_tie_gnt got=%b exp=01", bus.gnt); end
    bus.req = 2'b00;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (bus.done !== 2'b00) break;
    end
    checks++; if (bus.done !== 2'b01) begin failures++; $display("FAIL arst_next_done got=%b exp=01", bus.done); end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    bus.req   = 2'b00;
    bus.len0  = 3'd0;
    bus.len1  = 3'd0;
    bus.abort = 1'b0;
    test_reset();
    test_single();
    test_wrap();
    test_abort();
    test_back_to_back();
    test_len_change();
    test_async_rst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
